// File: rtl/ram_bist_pkg.sv
// Shared types and the address-derived test pattern for the RAM BIST controller.
package ram_bist_pkg;

    localparam int              AW_DEF   = 7;
    localparam int              DW_DEF   = 16;
    localparam logic [15:0]     SEED_DEF = 16'hA5C3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    // inv selects the complemented pattern used by the optional second pass.
    function automatic logic [DW_DEF-1:0] pat(input logic [DW_DEF-1:0] a,
                                             input logic [DW_DEF-1:0] seed,
                                             input logic              inv);
        return (a ^ seed) ^ {DW_DEF{inv}};
    endfunction

endpackage

// File: rtl/ram_bist_expect_pipe.sv
// Delay line carrying {valid, addr, expected} alongside the RAM read latency.
module ram_bist_expect_pipe
    import ram_bist_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t stage [DEPTH];

    // NOTE: this is a register array, not a RAM, so it can and must be cleared:
    // a stale valid bit surviving reset would score a phantom compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= '{valid: in_valid, addr: in_addr, data: in_data};
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_valid = stage[DEPTH-1].valid;
    assign out_addr  = stage[DEPTH-1].addr;
    assign out_data  = stage[DEPTH-1].data;

endmodule

// File: rtl/ram_bist_ctrl.sv
// Write-then-read self test of the pipelined single-port RAM macro.
// Optional complemented second pass: define RAM_BIST_INVERT_PASS_EN.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int          AW       = AW_DEF,
    parameter int          DW       = DW_DEF,
    parameter int          READ_LAT = 2,
    parameter logic [DW-1:0] SEED   = SEED_DEF,
    parameter int          CW       = AW + 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [CW-1:0] fail_count,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_wen,
    output logic          ram_oen,
    input  logic [DW-1:0] ram_q
);

    localparam int DCW = $clog2(READ_LAT + 1);

    state_t          state;
    logic [AW-1:0]   addr;
    logic [DCW-1:0]  drain_cnt;
    logic            inv;
    logic            push_valid;
    logic [DW-1:0]   push_data;
    logic [DW-1:0]   cur_pat;
    logic            exp_valid;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_data;
    logic            mismatch;
    logic [CW-1:0]   count_next;

`ifndef RAM_BIST_INVERT_PASS_EN
    assign inv = 1'b0;
`endif

    assign cur_pat = DW'(pat(DW_DEF'(addr), DW_DEF'(SEED), inv));

    // Pushed from the registered read request so the entry leaves the pipe
    // in the same cycle the macro presents the matching Q.
    ram_bist_expect_pipe #(.AW(AW), .DW(DW), .DEPTH(READ_LAT)) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (push_valid),
        .in_addr   (ram_a),
        .in_data   (push_data),
        .out_valid (exp_valid),
        .out_addr  (exp_addr),
        .out_data  (exp_data)
    );

    assign mismatch = exp_valid && (ram_q != exp_data);

    always_comb begin
        count_next = fail_count;
        if (mismatch && (fail_count != '1)) count_next = fail_count + CW'(1);
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, regardless of statement order in this block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            drain_cnt  <= '0;
            push_valid <= 1'b0;
            push_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
            ram_a      <= '0;
            ram_d      <= '0;
            ram_wen    <= 1'b1;
            ram_oen    <= 1'b1;
`ifdef RAM_BIST_INVERT_PASS_EN
            inv        <= 1'b0;
`endif
        end else begin
            push_valid <= 1'b0;
            ram_d      <= '0;
            ram_wen    <= 1'b1;
            ram_oen    <= 1'b1;

            if (mismatch) begin
                if (fail_count == '0) fail_addr <= exp_addr;
                fail_count <= count_next;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_WRITE;
                        addr       <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_addr  <= '0;
                        fail_count <= '0;
`ifdef RAM_BIST_INVERT_PASS_EN
                        inv        <= 1'b0;
`endif
                    end
                end
                S_WRITE: begin
                    ram_a   <= addr;
                    ram_d   <= cur_pat;
                    ram_wen <= 1'b0;
                    addr    <= addr + AW'(1);
                    if (addr == '1) state <= S_READ;
                end
                S_READ: begin
                    ram_a      <= addr;
                    ram_oen    <= 1'b0;
                    push_valid <= 1'b1;
                    push_data  <= cur_pat;
                    addr       <= addr + AW'(1);
                    if (addr == '1) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    ram_oen   <= 1'b0;
                    drain_cnt <= drain_cnt + DCW'(1);
                    if (drain_cnt == DCW'(READ_LAT - 1)) begin
`ifdef RAM_BIST_INVERT_PASS_EN
                        if (!inv) begin
                            inv   <= 1'b1;
                            state <= S_WRITE;
                        end else begin
                            state <= S_DONE;
                        end
`else
                        state <= S_DONE;
`endif
                    end
                end
                S_DONE: begin
                    // The final read is compared on this same edge, hence count_next.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (count_next == '0);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Randomized self-checking bench for ram_bist_ctrl with a behavioural RAM and fault model.
module tb_ram_bist_ctrl;

    localparam int AW  = 7;
    localparam int DW  = 16;
    localparam int N   = 128;
    localparam int LAT = 2;
    localparam int CW  = AW + 2;
`ifdef RAM_BIST_INVERT_PASS_EN
    localparam int P = 2;
`else
    localparam int P = 1;
`endif
    localparam int DONE_EDGE = P * (2 * N + LAT) + 1;
    localparam logic [DW-1:0] SEED = 16'hA5C3;

    localparam int SAW = 4;
    localparam int SN  = 16;
    localparam int SCW = 3;

    logic          clk = 1'b0;
    logic          reset, start;
    logic          busy, done, pass, ram_wen, ram_oen;
    logic [AW-1:0] fail_addr, ram_a;
    logic [CW-1:0] fail_count;
    logic [DW-1:0] ram_d, ram_q;

    logic           s_start, s_busy, s_done, s_pass, s_wen, s_oen;
    logic [SAW-1:0] s_fail_addr, s_ram_a;
    logic [SCW-1:0] s_fail_count;
    logic [DW-1:0]  s_ram_d, s_ram_q;

    int tests_run    = 0;
    int tests_failed = 0;

    int fault_mode = 0;   // 0 clean, 1 stuck-at-1 bit, 2 every read inverted
    int fault_addr = 0;
    int fault_bit  = 0;
    int ram_lat    = LAT;

    int            obs_done_edge, obs_wen_cnt, obs_oen_cnt, obs_wr_err, obs_d_err, obs_busy_err;
    logic [DW-1:0] obs_d15;
    logic [18:0]   obs_edge0;

    always #5 clk = ~clk;

    ram_bist_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_count(fail_count), .ram_a(ram_a), .ram_d(ram_d),
        .ram_wen(ram_wen), .ram_oen(ram_oen), .ram_q(ram_q)
    );

    ram_bist_ctrl #(.AW(SAW), .CW(SCW)) dut_short (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done), .pass(s_pass),
        .fail_addr(s_fail_addr), .fail_count(s_fail_count), .ram_a(s_ram_a), .ram_d(s_ram_d),
        .ram_wen(s_wen), .ram_oen(s_oen), .ram_q(s_ram_q)
    );

    function automatic logic [DW-1:0] bpat(input int a, input int inv);
        logic [DW-1:0] v;
        v = DW'(a) ^ SEED;
        return (inv != 0) ? ~v : v;
    endfunction

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
        case (fault_mode)
            1:       return (a == fault_addr) ? (v | (16'd1 << fault_bit)) : v;
            2:       return ~v;
            default: return v;
        endcase
    endfunction

    // Behavioural RAM macro: Q appears ram_lat cycles after the address.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] rpipe [4];
    always @(posedge clk) begin
        if (!ram_wen) mem[ram_a] <= ram_d;
        rpipe[0] <= !ram_oen ? faulty(mem[ram_a], int'(ram_a)) : '0;
        for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_q = rpipe[ram_lat-1];

    logic [DW-1:0] s_mem [SN];
    logic [DW-1:0] s_pipe [2];
    always @(posedge clk) begin
        if (!s_wen) s_mem[s_ram_a] <= s_ram_d;
        s_pipe[0] <= !s_oen ? s_mem[s_ram_a] : '0;
        s_pipe[1] <= s_pipe[0];
    end
    assign s_ram_q = ~s_pipe[1];

    // Reference: what each compare should see, derived from the pattern rule and the fault.
    task automatic ref_model(output int exp_cnt, output int exp_faddr);
        logic [DW-1:0] e, obs;
        exp_cnt   = 0;
        exp_faddr = 0;
        for (int p = 0; p < P; p++) begin
            for (int a = 0; a < N; a++) begin
                e = bpat(a, p);
                if (ram_lat == LAT) obs = faulty(e, a);
                else                obs = (a == 0) ? '0 : faulty(bpat(a - 1, p), a - 1);
                if (obs != e) begin
                    if (exp_cnt == 0) exp_faddr = a;
                    if (exp_cnt < (2 ** CW) - 1) exp_cnt++;
                end
            end
        end
    endtask

    // Pulses start, then records pin activity edge by edge until done or the budget expires.
    task automatic run_bist(input int repulse_edge);
        int wr_idx;
        obs_done_edge = -1;
        obs_wen_cnt = 0; obs_oen_cnt = 0; obs_wr_err = 0; obs_d_err = 0; obs_busy_err = 0;
        obs_d15 = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        obs_edge0 = {busy, done, pass, fail_addr, fail_count};
        for (int e = 1; e < 4000; e++) begin
            start = (e == repulse_edge);
            @(negedge clk);
            start = 1'b0;
            if (!ram_wen) begin
                wr_idx = obs_wen_cnt;
                if (ram_a != AW'(wr_idx % N) || ram_d != bpat(wr_idx % N, wr_idx / N)) obs_wr_err++;
                if (wr_idx == 'h15) obs_d15 = ram_d;
                obs_wen_cnt++;
            end else if (ram_d != '0) begin
                obs_d_err++;
            end
            if (!ram_oen) obs_oen_cnt++;
            if (done) begin
                obs_done_edge = e;
                break;
            end
            if (!busy) obs_busy_err++;
        end
    endtask

    task automatic test_reset();
        logic [43:0] act, exp;
        exp = {7'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 9'd0};
        act = {ram_a, ram_d, ram_wen, ram_oen, busy, done, pass, fail_addr, fail_count};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected %h", act, exp);
        end
        tests_run++;
        if ({s_busy, s_done, s_pass, s_wen, s_oen, s_fail_count} !== {3'b000, 2'b11, 3'd0}) begin
            tests_failed++;
            $display("FAIL reset_short: got %b expected 00011000",
                     {s_busy, s_done, s_pass, s_wen, s_oen, s_fail_count});
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_clean();
        int ec, ea;
        fault_mode = 0; ram_lat = LAT;
        ref_model(ec, ea);
        run_bist(-1);
        tests_run++;
        if (obs_edge0 !== {1'b1, 18'd0}) begin
            tests_failed++; $display("FAIL clean_start_status: got %h expected %h", obs_edge0, {1'b1, 18'd0});
        end
        tests_run++;
        if (obs_done_edge != DONE_EDGE) begin
            tests_failed++; $display("FAIL clean_done_edge: got %0d expected %0d", obs_done_edge, DONE_EDGE);
        end
        tests_run++;
        if (obs_wen_cnt != P * N || obs_wr_err != 0) begin
            tests_failed++; $display("FAIL clean_writes: got %0d writes (%0d bad) expected %0d", obs_wen_cnt, obs_wr_err, P * N);
        end
        // Reads plus the drain cycles, which also hold OEN low.
        tests_run++;
        if (obs_oen_cnt != P * (N + LAT)) begin
            tests_failed++; $display("FAIL clean_oen_cycles: got %0d expected %0d", obs_oen_cnt, P * (N + LAT));
        end
        tests_run++;
        if (obs_d15 !== 16'hA5D6) begin
            tests_failed++; $display("FAIL clean_d_at_15: got %h expected a5d6", obs_d15);
        end
        tests_run++;
        if (obs_d_err != 0 || obs_busy_err != 0) begin
            tests_failed++; $display("FAIL clean_d_busy: got %0d d errors, %0d busy drops expected 0", obs_d_err, obs_busy_err);
        end
        tests_run++;
        if ({pass, fail_count} !== {ec == 0, CW'(ec)}) begin
            tests_failed++; $display("FAIL clean_result: got pass=%b count=%0d expected pass=1 count=%0d", pass, fail_count, ec);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({done, pass, busy} !== 3'b110) begin
            tests_failed++; $display("FAIL clean_sticky: got done/pass/busy=%b expected 110", {done, pass, busy});
        end
    endtask

    task automatic test_fault(input string name, input int mode, input int lat, input int fa, input int fb);
        int ec, ea;
        fault_mode = mode; ram_lat = lat; fault_addr = fa; fault_bit = fb;
        ref_model(ec, ea);
        run_bist(-1);
        tests_run++;
        if (obs_done_edge != DONE_EDGE || obs_edge0 !== {1'b1, 18'd0}) begin
            tests_failed++; $display("FAIL %s_timing: got done edge %0d start status %h expected %0d 40000",
                                     name, obs_done_edge, obs_edge0, DONE_EDGE);
        end
        tests_run++;
        if (pass !== (ec == 0) || fail_count !== CW'(ec) || fail_addr !== AW'(ea)) begin
            tests_failed++; $display("FAIL %s_result: got pass=%b count=%0d addr=%h expected pass=%b count=%0d addr=%h",
                                     name, pass, fail_count, fail_addr, ec == 0, ec, ea);
        end
        fault_mode = 0; ram_lat = LAT;
    endtask

    task automatic test_back_to_back();
        fault_mode = 0; ram_lat = LAT;
        run_bist(50);
        tests_run++;
        if (obs_done_edge != DONE_EDGE) begin
            tests_failed++; $display("FAIL restart_ignored: got done edge %0d expected %0d", obs_done_edge, DONE_EDGE);
        end
        tests_run++;
        if ({pass, fail_count} !== {1'b1, CW'(0)}) begin
            tests_failed++; $display("FAIL restart_result: got pass=%b count=%0d expected pass=1 count=0", pass, fail_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [43:0] act, exp;
        bit hit = 1'b0;
        int wen_lo = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!ram_wen && ram_a == 7'h40) begin
                hit = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!hit) begin
            tests_failed++; $display("FAIL reset_mid_reach: got no write at 40 expected one");
        end
        reset = 1'b1;
        @(negedge clk);
        exp = {7'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 9'd0};
        act = {ram_a, ram_d, ram_wen, ram_oen, busy, done, pass, fail_addr, fail_count};
        tests_run++;
        if (act !== exp) begin
            tests_failed++; $display("FAIL reset_mid_values: got %h expected %h", act, exp);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!ram_wen) wen_lo++;
        end
        tests_run++;
        if (wen_lo != 0) begin
            tests_failed++; $display("FAIL reset_mid_no_write: got %0d write cycles expected 0", wen_lo);
        end
        run_bist(-1);
        tests_run++;
        if (obs_done_edge != DONE_EDGE || {pass, fail_count} !== {1'b1, CW'(0)}) begin
            tests_failed++; $display("FAIL reset_mid_rerun: got edge %0d pass=%b count=%0d expected %0d 1 0",
                                     obs_done_edge, pass, fail_count, DONE_EDGE);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            test_fault("random_stuck", 1, LAT, int'($urandom_range(0, N - 1)), int'($urandom_range(0, DW - 1)));
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        bit finished = 1'b0;
        exp_cnt = (SN * P > (2 ** SCW) - 1) ? (2 ** SCW) - 1 : SN * P;
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (s_done) begin
                finished = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!finished || s_pass !== 1'b0 || s_fail_count !== SCW'(exp_cnt) || s_fail_addr !== '0) begin
            tests_failed++; $display("FAIL saturation: got done=%b pass=%b count=%0d addr=%h expected 1 0 %0d 0",
                                     finished, s_pass, s_fail_count, s_fail_addr, exp_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; s_start = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_clean();
        test_fault("stuck_15_b3", 1, LAT, 'h15, 3);
        test_fault("latency3", 0, 3, 0, 0);
        test_back_to_back();
        test_fault("all_inverted", 2, LAT, 0, 0);
        test_reset_mid();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
